serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial subtractor computing diff = a - b - bin over WIDTH-bit unsigned operands, one bit per clock, LSB first. It uses a single combinational full-subtractor cell and a registered borrow. It is the counterpart to the combinational full-adder cell and trades area for latency. It sits behind a start/done handshake so a host FSM or testbench can launch operations back-to-back.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden)

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  synchronous reset, active-low; sampled on rising clk edge
start  input  1  request an operation; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepting edge
b  input  WIDTH  subtrahend; captured on the accepting edge
bin  input  1  borrow-in; captured on the accepting edge
busy  output  1  high from the cycle after acceptance until done has been shown
done  output  1  single-cycle pulse; diff and bout are valid in that cycle
diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH
bout  output  1  final borrow-out; 1 means a < b + bin

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and counter are cleared.
  - Reset has priority over every other event.
- State IDLE:
  - start=1 at edge k: a_sh<=a, b_sh<=b, br<=bin, cnt<=0, res_sh<=0, go to SHIFT.
  - start=0: remain in IDLE.
- State SHIFT, per edge:
  - d = a_sh[0]^b_sh[0]^br.
  - br <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br).
  - res_sh <= {d, res_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; cnt++.
  - On the edge where cnt==WIDTH-1: diff<={d, res_sh[WIDTH-1:1]}, bout<=next br, go to DONE.
- State DONE: done=1 for exactly this cycle; next edge returns to IDLE.
- Latency:
  - start sampled at edge k; SHIFT occupies edges k+1..k+WIDTH; done is high in the cycle after edge k+WIDTH.
  - Back-to-back: the earliest next acceptance is the edge leaving DONE+1, i.e. every WIDTH+2 cycles.
- busy = (state != IDLE), registered via state. done = (state == DONE).
- start while busy=1 is ignored, not queued. Operands may change freely while busy.
- diff and bout hold their last result until the next DONE. They are not cleared at start.
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - bout equals the borrow of the full WIDTH-bit chain, identical to bit WIDTH of {1'b0,a} - {1'b0,b} - bin, taken as a borrow.
- Reset mid-operation: the operation is abandoned, no done pulse is produced, and outputs return to 0 per the reset values.
- start asserted in the same cycle as rst_n=0: reset wins and start is not accepted.

Decomposition:
- Shared package sub_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
- Sub-module full_subtractor (a, b, bin -> d, bout), purely combinational.
  - Instantiated once in the datapath.
  - Mirrors the existing full-adder cell so it can be unit-tested exhaustively on its own.

Test Plan:
- a=200, b=55, bin=0, start pulse -> done exactly 9 cycles after the start edge; diff=145, bout=0; busy high for 9 cycles.
- a=5, b=10, bin=0 -> diff=251, bout=1; then a=0, b=0, bin=1 -> diff=255, bout=1; then a=255, b=255, bin=0 -> diff=0, bout=0.
- Hold start=1 continuously with changing a/b -> a new operation is accepted every 10 cycles, each result matches the operands captured at its own acceptance edge, and mid-operation changes to a/b have no effect.
- Assert rst_n=0 for one edge in the 4th SHIFT cycle of a=100, b=1 -> no done pulse; busy=0, diff=0, bout=0 next cycle; a fresh start then yields diff=99, bout=0.
- full_subtractor standalone: all 8 input combinations -> d and bout match the truth table.
- Randomized: 1000 operations with random a, b, bin and random start gaps -> each done compared against a golden model ((a-b-bin) mod 256, borrow = a<b+bin); zero mismatches.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtractor: default width and FSM state encoding.
package sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StShift = ST_SHIFT,
        StDone  = ST_DONE
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, bout is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock behind a start/done handshake.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             fs_d, fs_bout;

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        bout_d   = bout_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    br_d     = bin;
                    cnt_d    = '0;
                    res_sh_d = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = {fs_d, res_sh_q[WIDTH-1:1]};
                br_d     = fs_bout;
                cnt_d    = cnt_q + 1'b1;
                // Last bit: publish the fully assembled word, including this bit.
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {fs_d, res_sh_q[WIDTH-1:1]};
                    bout_d  = fs_bout;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            bout_q   <= bout_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks for serial_subtractor and the full_subtractor cell.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    logic fa, fb, fbin, fd, fbout;

    int checks;
    int errors;

    serial_subtractor #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    full_subtractor u_cell (
        .a    (fa),
        .b    (fb),
        .bin  (fbin),
        .d    (fd),
        .bout (fbout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation; returns result, edges from accept to done (-1 on timeout).
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                         output logic [7:0] od, output logic obo, output int lat);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        od = '0;
        obo = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                od  = diff;
                obo = bout;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd0 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b diff=%0d bout=%b, want 0 0 0 0",
                     busy, done, diff, bout);
        end
        rst_n = 1'b1; start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int busy_cnt;
        int done_edge;
        a = 8'd200; b = 8'd55; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; a = 8'd0; b = 8'd0;
        busy_cnt = 0;
        done_edge = -1;
        for (int i = 1; i <= 15; i++) begin
            if (busy) busy_cnt++;
            if (done && done_edge < 0) begin
                done_edge = i - 1;
                checks++;
                if (diff !== 8'd145 || bout !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_result: diff=%0d bout=%b want 145 0", diff, bout);
                end
            end
            tick();
        end
        checks++;
        if (done_edge != 8) begin
            errors++;
            $display("FAIL basic_latency: done after %0d edges want 8", done_edge);
        end
        checks++;
        if (busy_cnt != 9) begin
            errors++;
            $display("FAIL basic_busy_len: busy %0d cycles want 9", busy_cnt);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vbin [3];
        logic [7:0] ed [3];
        logic       eb [3];
        logic [7:0] od;
        logic       obo;
        int         lat;
        va = '{8'd5, 8'd0, 8'd255};
        vb = '{8'd10, 8'd0, 8'd255};
        vbin = '{1'b0, 1'b1, 1'b0};
        ed = '{8'd251, 8'd255, 8'd0};
        eb = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vbin[i], od, obo, lat);
            checks++;
            if (lat != 8 || od !== ed[i] || obo !== eb[i]) begin
                errors++;
                $display("FAIL vector_%0d: lat=%0d diff=%0d bout=%b want 8 %0d %b",
                         i, lat, od, obo, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ea, eb;
        logic       ebin;
        logic [8:0] full;
        int         seen;
        seen = 0;
        start = 1'b1;
        for (int i = 0; i < 42; i++) begin
            a = 8'((i * 37 + 11) & 255);
            b = 8'((i * 91 + 200) & 255);
            bin = 1'(i & 1);
            if (i >= 31) start = 1'b0;
            tick();
            checks++;
            if (done !== ((i % 10) == 8 && i < 40)) begin
                errors++;
                $display("FAIL b2b_done_edge%0d: done=%b", i, done);
            end
            if ((i % 10) == 8 && done) begin
                seen++;
                ea = 8'(((i - 8) * 37 + 11) & 255);
                eb = 8'(((i - 8) * 91 + 200) & 255);
                ebin = 1'((i - 8) & 1);
                full = {1'b0, ea} - {1'b0, eb} - {8'd0, ebin};
                checks++;
                if (diff !== full[7:0] || bout !== full[8]) begin
                    errors++;
                    $display("FAIL b2b_result_edge%0d: diff=%0d bout=%b want %0d %b",
                             i, diff, bout, full[7:0], full[8]);
                end
            end
        end
        checks++;
        if (seen != 4) begin
            errors++;
            $display("FAIL b2b_count: %0d results want 4", seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] od;
        logic       obo;
        int         lat;
        int         dones;
        a = 8'd100; b = 8'd1; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd0 || bout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: busy=%b done=%b diff=%0d bout=%b want 0 0 0 0",
                     busy, done, diff, bout);
        end
        dones = 0;
        repeat (12) begin
            tick();
            if (done) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midreset_no_done: %0d done pulses want 0", dones);
        end
        do_op(8'd100, 8'd1, 1'b0, od, obo, lat);
        checks++;
        if (lat != 8 || od !== 8'd99 || obo !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart: lat=%0d diff=%0d bout=%b want 8 99 0", lat, od, obo);
        end
    endtask

    task automatic test_full_subtractor();
        logic [7:0] d_tab;
        logic [7:0] b_tab;
        logic [2:0] idx;
        d_tab = 8'b1001_0110;
        b_tab = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            {fa, fb, fbin} = idx;
            #1;
            checks++;
            if (fd !== d_tab[idx] || fbout !== b_tab[idx]) begin
                errors++;
                $display("FAIL cell_%0d: d=%b bout=%b want %b %b",
                         i, fd, fbout, d_tab[idx], b_tab[idx]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ra, rb, od;
        logic       rbin, obo;
        logic [8:0] full;
        int         lat;
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            do_op(ra, rb, rbin, od, obo, lat);
            checks++;
            if (lat != 8 || od !== full[7:0] || obo !== full[8]) begin
                errors++;
                $display("FAIL random_%0d: a=%0d b=%0d bin=%b lat=%0d diff=%0d bout=%b want %0d %b",
                         n, ra, rb, rbin, lat, od, obo, full[7:0], full[8]);
            end
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        fa = 1'b0; fb = 1'b0; fbin = 1'b0;
        test_reset();
        test_basic();
        test_vectors();
        test_back_to_back();
        test_reset_mid();
        test_full_subtractor();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
